// File: rtl/axis_fifo_pkt.sv
`default_nettype none
// ============================================================================
//  Module      : axis_fifo_pkt
//  Description : AXI-Stream synchronous FIFO with TLAST storage, fill-level
//                and packet-count reporting, almost-full/almost-empty
//                watermarks and an optional store-and-forward packet mode.
//
//  Parameters  : DEPTH          number of entries (power of two, >= 2)
//                WIDTH          tdata width in bits
//                PACKET_MODE    0 = cut-through, 1 = store-and-forward
//                AFULL_THRESH   almost_full when level >= this value
//                AEMPTY_THRESH  almost_empty when level <= this value
//
//  Ports       : clk, rst                 clock, async active-high reset
//                s_axis_tdata/tlast/tvalid/tready   write-side stream
//                m_axis_tdata/tlast/tvalid/tready   read-side stream
//                level        stored beat count, 0..DEPTH
//                pkt_count    complete packets stored (beats with tlast)
//                almost_full  level >= AFULL_THRESH
//                almost_empty level <= AEMPTY_THRESH
//
//  Revision    : 1.0  initial release
// ============================================================================
module axis_fifo_pkt #(
   parameter int DEPTH         = 16,
   parameter int WIDTH         = 8,
   parameter int PACKET_MODE   = 0,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic [WIDTH-1:0]          s_axis_tdata,
   input  logic                      s_axis_tlast,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,

   output logic [WIDTH-1:0]          m_axis_tdata,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,

   output logic [$clog2(DEPTH):0]    level,
   output logic [$clog2(DEPTH):0]    pkt_count,
   output logic                      almost_full,
   output logic                      almost_empty
);

   // Pointers carry one extra MSB as a wrap bit so full and empty can be
   // told apart when the address bits coincide.
   localparam int                c_addr_w        = $clog2(DEPTH);
   localparam int                c_ptr_w         = c_addr_w + 1;
   localparam logic [c_ptr_w-1:0] c_ptr_one      = c_ptr_w'(1);
   localparam logic [c_ptr_w-1:0] c_afull_thresh = c_ptr_w'(AFULL_THRESH);
   localparam logic [c_ptr_w-1:0] c_aempty_thresh = c_ptr_w'(AEMPTY_THRESH);
   localparam logic              c_store_fwd     = (PACKET_MODE != 0);

   // Storage: each entry is {tlast, tdata}
   logic [WIDTH:0]       r_mem [DEPTH];

   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_ptr_w-1:0]   r_pkt_count;
   logic                 r_draining;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_wr;
   logic                 w_rd;
   logic                 w_wr_last;
   logic                 w_rd_last;
   logic                 w_pkt_ready;
   logic [c_ptr_w-1:0]   w_level;
   logic [WIDTH:0]       w_head;

   // ------------------------------------------------------------------
   // Status derived purely from registered pointers and counters
   // ------------------------------------------------------------------
   assign w_full  = (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]) &&
                    (r_wr_ptr[c_addr_w]     != r_rd_ptr[c_addr_w]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_level = r_wr_ptr - r_rd_ptr;

   assign level        = w_level;
   assign pkt_count    = r_pkt_count;
   assign almost_full  = (w_level >= c_afull_thresh);
   assign almost_empty = (w_level <= c_aempty_thresh);

   // ------------------------------------------------------------------
   // Write side: refuse while full even if a read is happening this
   // cycle, so tready never depends on the consumer.
   // ------------------------------------------------------------------
   assign s_axis_tready = !w_full && !rst;
   assign w_wr          = s_axis_tvalid && s_axis_tready;
   assign w_wr_last     = w_wr && s_axis_tlast;

   // ------------------------------------------------------------------
   // Read side: first-word-fall-through from the head entry.
   // In store-and-forward mode a beat is only presented once a whole
   // packet is buffered; a full FIFO releases an oversize packet
   // cut-through, and the draining flag keeps tvalid up until that
   // packet's tlast has left, even after full drops away.
   // ------------------------------------------------------------------
   assign w_head        = r_mem[r_rd_ptr[c_addr_w-1:0]];
   assign m_axis_tdata  = w_head[WIDTH-1:0];
   assign m_axis_tlast  = w_head[WIDTH];

   assign w_pkt_ready   = !c_store_fwd || (r_pkt_count != '0) || w_full || r_draining;
   assign m_axis_tvalid = !w_empty && w_pkt_ready;

   assign w_rd          = m_axis_tvalid && m_axis_tready;
   assign w_rd_last     = w_rd && m_axis_tlast;

   // ------------------------------------------------------------------
   // Data array: contents are don't-care after reset, so no reset here.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr[c_addr_w-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   // ------------------------------------------------------------------
   // Pointers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
      end
   end

   // ------------------------------------------------------------------
   // Complete-packet counter. It can never exceed DEPTH because every
   // counted packet occupies at least one stored entry.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pkt_count <= '0;
      end else begin
         case ({w_wr_last, w_rd_last})
            2'b10:   r_pkt_count <= r_pkt_count + c_ptr_one;
            2'b01:   r_pkt_count <= r_pkt_count - c_ptr_one;
            default: r_pkt_count <= r_pkt_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Draining flag: set by a non-last read, cleared by a tlast read.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_draining <= 1'b0;
      end else if (w_rd) begin
         r_draining <= !m_axis_tlast;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_pkt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_fifo_pkt
//  Description : Directed self-checking bench for axis_fifo_pkt. Instance
//                u_dut0 runs cut-through, u_dut1 store-and-forward; both
//                DEPTH=16, WIDTH=8.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axis_fifo_pkt;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [7:0] s0_tdata, s1_tdata, m0_tdata, m1_tdata;
   logic       s0_tlast, s1_tlast, m0_tlast, m1_tlast;
   logic       s0_tvalid, s1_tvalid, m0_tvalid, m1_tvalid;
   logic       s0_tready, s1_tready, m0_tready, m1_tready;
   logic [4:0] level0, level1, pkt0, pkt1;
   logic       af0, af1, ae0, ae1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axis_fifo_pkt #(.DEPTH(16), .WIDTH(8), .PACKET_MODE(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s0_tdata), .s_axis_tlast(s0_tlast),
      .s_axis_tvalid(s0_tvalid), .s_axis_tready(s0_tready),
      .m_axis_tdata(m0_tdata), .m_axis_tlast(m0_tlast),
      .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready),
      .level(level0), .pkt_count(pkt0),
      .almost_full(af0), .almost_empty(ae0)
   );

   axis_fifo_pkt #(.DEPTH(16), .WIDTH(8), .PACKET_MODE(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s1_tdata), .s_axis_tlast(s1_tlast),
      .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
      .m_axis_tdata(m1_tdata), .m_axis_tlast(m1_tlast),
      .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
      .level(level1), .pkt_count(pkt1),
      .almost_full(af1), .almost_empty(ae1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------
   task automatic test_reset();
      s0_tvalid = 1'b1; s0_tdata = 8'hEE;
      s1_tvalid = 1'b1; s1_tdata = 8'hEE; s1_tlast = 1'b1;
      repeat (3) begin
         step();
         n_checks++; if (s0_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready0: got %b expected 0", s0_tready); end
         n_checks++; if (s1_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready1: got %b expected 0", s1_tready); end
         n_checks++; if (m0_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid0: got %b expected 0", m0_tvalid); end
         n_checks++; if (m1_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid1: got %b expected 0", m1_tvalid); end
         n_checks++; if (level0 !== 5'd0) begin n_fail++; $display("FAIL reset_level0: got %0d expected 0", level0); end
         n_checks++; if (pkt1 !== 5'd0) begin n_fail++; $display("FAIL reset_pkt1: got %0d expected 0", pkt1); end
         n_checks++; if (ae0 !== 1'b1) begin n_fail++; $display("FAIL reset_aempty0: got %b expected 1", ae0); end
         n_checks++; if (af0 !== 1'b0) begin n_fail++; $display("FAIL reset_afull0: got %b expected 0", af0); end
      end
      s0_tvalid = 1'b0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
      rst = 1'b0;
      step();
      n_checks++; if (s0_tready !== 1'b1) begin n_fail++; $display("FAIL release_s_tready0: got %b expected 1", s0_tready); end
      n_checks++; if (s1_tready !== 1'b1) begin n_fail++; $display("FAIL release_s_tready1: got %b expected 1", s1_tready); end
      n_checks++; if (level0 !== 5'd0) begin n_fail++; $display("FAIL release_level0: got %0d expected 0", level0); end
   endtask

   // ---------------------------------------------------------------
   task automatic test_fill_drain();
      m0_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (s0_tready !== 1'b1) begin n_fail++; $display("FAIL fill_s_tready[%0d]: got %b expected 1", i, s0_tready); end
         n_checks++; if (level0 !== 5'(i)) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, level0, i); end
         n_checks++; if (af0 !== (i >= 14)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, af0, (i >= 14)); end
         n_checks++; if (ae0 !== (i <= 2)) begin n_fail++; $display("FAIL fill_aempty[%0d]: got %b expected %b", i, ae0, (i <= 2)); end
         n_checks++; if (m0_tvalid !== (i != 0)) begin n_fail++; $display("FAIL fill_m_tvalid[%0d]: got %b expected %b", i, m0_tvalid, (i != 0)); end
         s0_tvalid = 1'b1; s0_tdata = 8'(i); s0_tlast = (i == 15);
         step();
      end
      s0_tvalid = 1'b0; s0_tlast = 1'b0;
      n_checks++; if (s0_tready !== 1'b0) begin n_fail++; $display("FAIL full_s_tready: got %b expected 0", s0_tready); end
      n_checks++; if (level0 !== 5'd16) begin n_fail++; $display("FAIL full_level: got %0d expected 16", level0); end
      n_checks++; if (af0 !== 1'b1) begin n_fail++; $display("FAIL full_afull: got %b expected 1", af0); end
      n_checks++; if (pkt0 !== 5'd1) begin n_fail++; $display("FAIL full_pkt: got %0d expected 1", pkt0); end
      m0_tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (m0_tvalid !== 1'b1) begin n_fail++; $display("FAIL drain_tvalid[%0d]: got %b expected 1", i, m0_tvalid); end
         n_checks++; if (m0_tdata !== 8'(i)) begin n_fail++; $display("FAIL drain_tdata[%0d]: got %h expected %h", i, m0_tdata, 8'(i)); end
         n_checks++; if (m0_tlast !== (i == 15)) begin n_fail++; $display("FAIL drain_tlast[%0d]: got %b expected %b", i, m0_tlast, (i == 15)); end
         n_checks++; if (level0 !== 5'(16 - i)) begin n_fail++; $display("FAIL drain_level[%0d]: got %0d expected %0d", i, level0, 16 - i); end
         step();
      end
      m0_tready = 1'b0;
      n_checks++; if (m0_tvalid !== 1'b0) begin n_fail++; $display("FAIL drained_tvalid: got %b expected 0", m0_tvalid); end
      n_checks++; if (ae0 !== 1'b1) begin n_fail++; $display("FAIL drained_aempty: got %b expected 1", ae0); end
      n_checks++; if (pkt0 !== 5'd0) begin n_fail++; $display("FAIL drained_pkt: got %0d expected 0", pkt0); end
   endtask

   // ---------------------------------------------------------------
   task automatic test_full_simul();
      m0_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s0_tvalid = 1'b1; s0_tdata = 8'(8'h10 + i); s0_tlast = 1'b0;
         step();
      end
      // Full: write 0x55 must be refused while 0x10 is read
      s0_tdata = 8'h55; m0_tready = 1'b1;
      n_checks++; if (s0_tready !== 1'b0) begin n_fail++; $display("FAIL fsim_s_tready: got %b expected 0", s0_tready); end
      n_checks++; if (level0 !== 5'd16) begin n_fail++; $display("FAIL fsim_level16: got %0d expected 16", level0); end
      step();
      n_checks++; if (level0 !== 5'd15) begin n_fail++; $display("FAIL fsim_level15: got %0d expected 15", level0); end
      n_checks++; if (s0_tready !== 1'b1) begin n_fail++; $display("FAIL fsim_s_tready_free: got %b expected 1", s0_tready); end
      n_checks++; if (m0_tdata !== 8'h11) begin n_fail++; $display("FAIL fsim_head: got %h expected 11", m0_tdata); end
      s0_tdata = 8'h56;
      step();
      n_checks++; if (level0 !== 5'd15) begin n_fail++; $display("FAIL fsim_level_hold: got %0d expected 15", level0); end
      s0_tvalid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         logic [7:0] exp_d;
         exp_d = (i < 14) ? 8'(8'h12 + i) : 8'h56;
         n_checks++; if (m0_tdata !== exp_d || m0_tvalid !== 1'b1) begin n_fail++; $display("FAIL fsim_drain[%0d]: got %b/%h expected 1/%h", i, m0_tvalid, m0_tdata, exp_d); end
         step();
      end
      m0_tready = 1'b0;
      n_checks++; if (m0_tvalid !== 1'b0) begin n_fail++; $display("FAIL fsim_empty: got %b expected 0", m0_tvalid); end
   endtask

   // ---------------------------------------------------------------
   task automatic test_packet();
      m1_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (m1_tvalid !== 1'b0) begin n_fail++; $display("FAIL pkt_hold[%0d]: got %b expected 0", i, m1_tvalid); end
         s1_tvalid = 1'b1; s1_tdata = 8'(8'hA0 + i); s1_tlast = (i == 3);
         step();
      end
      s1_tvalid = 1'b0; s1_tlast = 1'b0;
      n_checks++; if (pkt1 !== 5'd1) begin n_fail++; $display("FAIL pkt_count_up: got %0d expected 1", pkt1); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (m1_tvalid !== 1'b1) begin n_fail++; $display("FAIL pkt_tvalid[%0d]: got %b expected 1", i, m1_tvalid); end
         n_checks++; if (m1_tdata !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL pkt_tdata[%0d]: got %h expected %h", i, m1_tdata, 8'(8'hA0 + i)); end
         n_checks++; if (m1_tlast !== (i == 3)) begin n_fail++; $display("FAIL pkt_tlast[%0d]: got %b expected %b", i, m1_tlast, (i == 3)); end
         step();
      end
      n_checks++; if (m1_tvalid !== 1'b0) begin n_fail++; $display("FAIL pkt_done_tvalid: got %b expected 0", m1_tvalid); end
      n_checks++; if (pkt1 !== 5'd0) begin n_fail++; $display("FAIL pkt_count_down: got %0d expected 0", pkt1); end
      m1_tready = 1'b0;
   endtask

   // ---------------------------------------------------------------
   task automatic test_oversize();
      int wr_i, rd_i, cyc;
      logic w, r;
      m1_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (m1_tvalid !== 1'b0) begin n_fail++; $display("FAIL ovs_hold[%0d]: got %b expected 0", i, m1_tvalid); end
         s1_tvalid = 1'b1; s1_tdata = 8'(8'h30 + i); s1_tlast = 1'b0;
         step();
      end
      n_checks++; if (m1_tvalid !== 1'b1) begin n_fail++; $display("FAIL ovs_escape: got %b expected 1", m1_tvalid); end
      n_checks++; if (level1 !== 5'd16) begin n_fail++; $display("FAIL ovs_level: got %0d expected 16", level1); end
      wr_i = 16; rd_i = 0; cyc = 0;
      m1_tready = 1'b1;
      while (rd_i < 20 && cyc < 200) begin
         s1_tvalid = (wr_i < 20);
         s1_tdata  = 8'(8'h30 + wr_i);
         s1_tlast  = (wr_i == 19);
         n_checks++; if (m1_tvalid !== 1'b1) begin n_fail++; $display("FAIL ovs_tvalid[%0d]: got %b expected 1", rd_i, m1_tvalid); end
         if (m1_tvalid === 1'b1) begin
            n_checks++; if (m1_tdata !== 8'(8'h30 + rd_i) || m1_tlast !== (rd_i == 19)) begin n_fail++; $display("FAIL ovs_beat[%0d]: got %b/%h expected %b/%h", rd_i, m1_tlast, m1_tdata, (rd_i == 19), 8'(8'h30 + rd_i)); end
         end
         w = s1_tvalid && s1_tready;
         r = m1_tvalid;
         step();
         if (w) wr_i++;
         if (r) rd_i++;
         cyc++;
      end
      s1_tvalid = 1'b0; s1_tlast = 1'b0; m1_tready = 1'b0;
      n_checks++; if (rd_i != 20) begin n_fail++; $display("FAIL ovs_count: got %0d expected 20", rd_i); end
      n_checks++; if (m1_tvalid !== 1'b0 || level1 !== 5'd0 || pkt1 !== 5'd0) begin n_fail++; $display("FAIL ovs_end: got tvalid %b level %0d pkt %0d expected 0 0 0", m1_tvalid, level1, pkt1); end
   endtask

   // ---------------------------------------------------------------
   task automatic test_backpressure();
      logic [8:0] q[$];
      logic [7:0] seq = 8'd0;
      logic       pv = 1'b0, prdy = 1'b1, plast = 1'b0;
      logic [7:0] pdata = 8'd0;
      logic       w, r;
      int         npk;
      for (int c = 0; c < 300; c++) begin
         s0_tvalid = ($urandom_range(0, 3) != 0);
         s0_tdata  = seq;
         s0_tlast  = ($urandom_range(0, 3) == 0);
         m0_tready = ($urandom_range(0, 1) == 1);
         if (pv && !prdy) begin
            n_checks++; if (m0_tvalid !== 1'b1 || m0_tdata !== pdata || m0_tlast !== plast) begin n_fail++; $display("FAIL bp_stable[%0d]: got %b/%h/%b expected 1/%h/%b", c, m0_tvalid, m0_tdata, m0_tlast, pdata, plast); end
         end
         npk = 0;
         foreach (q[k]) if (q[k][8]) npk++;
         n_checks++; if (level0 !== 5'(q.size()) || pkt0 !== 5'(npk)) begin n_fail++; $display("FAIL bp_level[%0d]: got %0d/%0d expected %0d/%0d", c, level0, pkt0, q.size(), npk); end
         n_checks++; if (m0_tvalid !== (q.size() != 0) || s0_tready !== (q.size() < 16)) begin n_fail++; $display("FAIL bp_flags[%0d]: got %b/%b expected %b/%b", c, m0_tvalid, s0_tready, (q.size() != 0), (q.size() < 16)); end
         n_checks++; if (af0 !== (q.size() >= 14) || ae0 !== (q.size() <= 2)) begin n_fail++; $display("FAIL bp_water[%0d]: got %b/%b expected %b/%b", c, af0, ae0, (q.size() >= 14), (q.size() <= 2)); end
         if (q.size() != 0) begin
            n_checks++; if ({m0_tlast, m0_tdata} !== q[0]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", c, {m0_tlast, m0_tdata}, q[0]); end
         end
         w = s0_tvalid && (q.size() < 16);
         r = m0_tready && (q.size() != 0);
         pv = m0_tvalid; prdy = m0_tready; pdata = m0_tdata; plast = m0_tlast;
         step();
         if (r) void'(q.pop_front());
         if (w) begin q.push_back({s0_tlast, s0_tdata}); seq++; end
      end
      s0_tvalid = 1'b0; m0_tready = 1'b1;
      repeat (17) step();
      m0_tready = 1'b0;
      n_checks++; if (level0 !== 5'd0) begin n_fail++; $display("FAIL bp_final_level: got %0d expected 0", level0); end
   endtask

   // ---------------------------------------------------------------
   task automatic test_backpressure_pkt();
      logic [8:0] q[$];
      logic [7:0] seq = 8'd0;
      logic       pv = 1'b0, prdy = 1'b1, plast = 1'b0;
      logic [7:0] pdata = 8'd0;
      logic       w, r;
      for (int c = 0; c < 300; c++) begin
         s1_tvalid = ($urandom_range(0, 1) == 1);
         s1_tdata  = seq;
         s1_tlast  = ($urandom_range(0, 3) == 0);
         m1_tready = ($urandom_range(0, 2) != 0);
         if (pv && !prdy) begin
            n_checks++; if (m1_tvalid !== 1'b1 || m1_tdata !== pdata || m1_tlast !== plast) begin n_fail++; $display("FAIL bpp_stable[%0d]: got %b/%h/%b expected 1/%h/%b", c, m1_tvalid, m1_tdata, m1_tlast, pdata, plast); end
         end
         n_checks++; if (level1 !== 5'(q.size()) || s1_tready !== (q.size() < 16)) begin n_fail++; $display("FAIL bpp_level[%0d]: got %0d/%b expected %0d/%b", c, level1, s1_tready, q.size(), (q.size() < 16)); end
         if (m1_tvalid === 1'b1) begin
            n_checks++; if (q.size() == 0 || {m1_tlast, m1_tdata} !== q[0]) begin n_fail++; $display("FAIL bpp_data[%0d]: got %h expected %h", c, {m1_tlast, m1_tdata}, (q.size() != 0) ? q[0] : 9'h0); end
         end
         w = s1_tvalid && (q.size() < 16);
         r = m1_tvalid && m1_tready && (q.size() != 0);
         pv = m1_tvalid; prdy = m1_tready; pdata = m1_tdata; plast = m1_tlast;
         step();
         if (r) void'(q.pop_front());
         if (w) begin q.push_back({s1_tlast, s1_tdata}); seq++; end
      end
      s1_tvalid = 1'b0; m1_tready = 1'b0;
   endtask

   // ---------------------------------------------------------------
   task automatic test_reset_midop();
      m0_tready = 1'b0; m1_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s0_tvalid = 1'b1; s0_tdata = 8'(8'hC0 + i); s0_tlast = 1'b0;
         step();
      end
      s0_tvalid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      n_checks++; if (level0 !== 5'd0) begin n_fail++; $display("FAIL arst_level0: got %0d expected 0", level0); end
      n_checks++; if (m0_tvalid !== 1'b0 || s0_tready !== 1'b0) begin n_fail++; $display("FAIL arst_hs0: got %b/%b expected 0/0", m0_tvalid, s0_tready); end
      n_checks++; if (ae0 !== 1'b1 || af1 !== 1'b0) begin n_fail++; $display("FAIL arst_water: got %b/%b expected 1/0", ae0, af1); end
      n_checks++; if (pkt1 !== 5'd0 || level1 !== 5'd0 || m1_tvalid !== 1'b0) begin n_fail++; $display("FAIL arst_dut1: got %0d/%0d/%b expected 0/0/0", pkt1, level1, m1_tvalid); end
      step();
      rst = 1'b0;
      m1_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (m1_tvalid !== 1'b0) begin n_fail++; $display("FAIL post_rst_partial[%0d]: got %b expected 0", i, m1_tvalid); end
         n_checks++; if (m0_tvalid !== 1'b0 || level0 !== 5'd0) begin n_fail++; $display("FAIL post_rst_dut0[%0d]: got %b/%0d expected 0/0", i, m0_tvalid, level0); end
         s1_tvalid = 1'b1; s1_tdata = 8'(8'hD0 + i); s1_tlast = 1'b0;
         step();
      end
      s1_tvalid = 1'b0;
      n_checks++; if (m1_tvalid !== 1'b0 || level1 !== 5'd3) begin n_fail++; $display("FAIL post_rst_end: got %b/%0d expected 0/3", m1_tvalid, level1); end
   endtask

   // ---------------------------------------------------------------
   initial begin
      s0_tdata = '0; s0_tlast = 1'b0; s0_tvalid = 1'b0; m0_tready = 1'b0;
      s1_tdata = '0; s1_tlast = 1'b0; s1_tvalid = 1'b0; m1_tready = 1'b0;
      test_reset();
      test_fill_drain();
      test_full_simul();
      test_packet();
      test_oversize();
      test_backpressure();
      test_backpressure_pkt();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
